// File: rtl/accum_wr_seq.sv
// Write-burst sequencer: issues one accumulator row address per valid column-0 partial sum,
// then drains the write-skew pipeline before pulsing done. Optional counters: ACCUM_WR_SEQ_PERF_EN.
module accum_wr_seq #(
    parameter  int SYS_COL    = 16,
    parameter  int ACCUM_ROW  = 256,
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW),
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [CNT_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_accum,
    input  logic                  psum_valid,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic                  wr_accum_out,
    output logic                  busy,
    output logic                  done
`ifdef ACCUM_WR_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam int DRAIN_WIDTH = $clog2(SYS_COL + 1) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                 state, state_next;
    logic [ADDR_WIDTH-1:0]  ptr, ptr_next;
    logic [CNT_WIDTH-1:0]   rem, rem_next;
    logic                   mode, mode_next;
    logic [DRAIN_WIDTH-1:0] drain_cnt, drain_next;
    logic                   wr_en_next;
    logic [ADDR_WIDTH-1:0]  wr_addr_next;
    logic                   wr_accum_next;
    logic [CNT_WIDTH-1:0]   len_clamped;

    assign len_clamped = (cmd_len > CNT_WIDTH'(ACCUM_ROW)) ? CNT_WIDTH'(ACCUM_ROW) : cmd_len;
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_next    = state;
        ptr_next      = ptr;
        rem_next      = rem;
        mode_next     = mode;
        drain_next    = drain_cnt;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_out;
        wr_accum_next = wr_accum_out;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    ptr_next   = cmd_base;
                    rem_next   = len_clamped;
                    mode_next  = cmd_accum;
                    drain_next = '0;
                    state_next = (len_clamped != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (psum_valid) begin
                    wr_en_next    = 1'b1;
                    wr_addr_next  = ptr;
                    wr_accum_next = mode;
                    ptr_next      = (ptr == ADDR_WIDTH'(ACCUM_ROW - 1)) ? '0 : ptr + ADDR_WIDTH'(1);
                    rem_next      = rem - CNT_WIDTH'(1);
                    if (rem == CNT_WIDTH'(1)) begin
                        state_next = DRAIN;
                        drain_next = '0;
                    end
                end
            end
            DRAIN: begin
                // Counting 0..SYS_COL places done SYS_COL+1 cycles after the last write.
                if (drain_cnt == DRAIN_WIDTH'(SYS_COL)) begin
                    state_next = DONE;
                end else begin
                    drain_next = drain_cnt + DRAIN_WIDTH'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            ptr          <= '0;
            rem          <= '0;
            mode         <= 1'b0;
            drain_cnt    <= '0;
            wr_en_out    <= 1'b0;
            wr_addr_out  <= '0;
            wr_accum_out <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            rem          <= rem_next;
            mode         <= mode_next;
            drain_cnt    <= drain_next;
            wr_en_out    <= wr_en_next;
            wr_addr_out  <= wr_addr_next;
            wr_accum_out <= wr_accum_next;
            done         <= (state_next == DONE);
        end
    end

`ifdef ACCUM_WR_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (state == RUN && !psum_valid && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accum_wr_seq.sv
// Randomized bench for accum_wr_seq: a burst-level model predicts every write row, done timing
// and (when ACCUM_WR_SEQ_PERF_EN is defined) the performance counters.
module tb_accum_wr_seq;

    localparam int SYS_COL   = 16;
    localparam int ACCUM_ROW = 256;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_base = '0;
    logic [8:0] cmd_len = '0;
    logic       cmd_accum = 1'b0;
    logic       psum_valid = 1'b0;
    logic       wr_en_out;
    logic [7:0] wr_addr_out;
    logic       wr_accum_out;
    logic       busy;
    logic       done;
`ifdef ACCUM_WR_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    accum_wr_seq #(.SYS_COL(SYS_COL), .ACCUM_ROW(ACCUM_ROW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .cmd_accum    (cmd_accum),
        .psum_valid   (psum_valid),
        .wr_en_out    (wr_en_out),
        .wr_addr_out  (wr_addr_out),
        .wr_accum_out (wr_accum_out),
        .busy         (busy),
        .done         (done)
`ifdef ACCUM_WR_SEQ_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: last written row/mode and expected counter totals since reset.
    int last_addr = 0;
    int last_acc  = 0;
    int m_busy    = 0;
    int m_stall   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf();
`ifdef ACCUM_WR_SEQ_PERF_EN
        check("perf_busy", perf_busy_cycles, m_busy);
        check("perf_stall", perf_stall_cycles, m_stall);
`endif
    endtask

    task automatic do_reset(input int cycles);
        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        psum_valid = 1'b1;
        repeat (cycles) step();
        check("rst_wr_en", wr_en_out, 0);
        check("rst_addr", wr_addr_out, 0);
        check("rst_accum", wr_accum_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        rstn      = 1'b1;
        last_addr = 0;
        last_acc  = 0;
        m_busy    = 0;
        m_stall   = 0;
        check_perf();
    endtask

    // pv_mode: 0 = psum_valid always 1, 1 = random, 2 = pattern 1,0,0,1,1 then 1s.
    // abort_at > 0 asserts reset once that many rows have been written.
    task automatic run_burst(input int base, input int len, input bit accum,
                             input int pv_mode, input bit hold, input int abort_at);
        int  n;
        int  issued;
        int  exp_done;
        int  budget;
        bit  reached;
        bit  pv;
        bit  run_active;
        bit  pat [5];
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        n        = (len > ACCUM_ROW) ? ACCUM_ROW : len;
        issued   = 0;
        exp_done = (n == 0) ? 0 : -1;
        budget   = n * 16 + SYS_COL + 64;
        reached  = (n == 0);

        cmd_valid  = 1'b1;
        cmd_base   = base[7:0];
        cmd_len    = len[8:0];
        cmd_accum  = accum;
        psum_valid = 1'($urandom % 2);
        step();
        if (!hold) cmd_valid = 1'b0;
        check("acc_wr_en", wr_en_out, 0);
        check("acc_done", done, (n == 0) ? 1 : 0);
        check("acc_busy", busy, 1);
        check("acc_ready", cmd_ready, 0);

        if (n != 0) begin
            for (int cyc = 1; cyc <= budget; cyc++) begin
                case (pv_mode)
                    0:       pv = 1'b1;
                    1:       pv = (($urandom % 4) != 0);
                    default: pv = (cyc <= 5) ? pat[cyc-1] : 1'b1;
                endcase
                run_active = (issued < n);
                psum_valid = pv;
                step();
                m_busy++;
                if (run_active && !pv) m_stall++;
                if (run_active && pv) begin
                    issued++;
                    last_addr = (base + issued - 1) % ACCUM_ROW;
                    last_acc  = accum;
                    if (issued == n) exp_done = cyc + SYS_COL + 1;
                end
                check("wr_en", wr_en_out, (run_active && pv) ? 1 : 0);
                check("wr_addr", wr_addr_out, last_addr);
                check("wr_accum", wr_accum_out, last_acc);
                check("done", done, (cyc == exp_done) ? 1 : 0);
                check("ready_busy", cmd_ready, 0);

                if (abort_at > 0 && issued == abort_at && run_active && pv) begin
                    cmd_valid  = 1'b0;
                    psum_valid = 1'b1;
                    rstn       = 1'b0;
                    step();
                    rstn      = 1'b1;
                    last_addr = 0;
                    last_acc  = 0;
                    m_busy    = 0;
                    m_stall   = 0;
                    check("abort_wr_en", wr_en_out, 0);
                    check("abort_done", done, 0);
                    check("abort_busy", busy, 0);
                    check("abort_ready", cmd_ready, 1);
                    repeat (SYS_COL + 4) begin
                        step();
                        check("post_abort_wr_en", wr_en_out, 0);
                        check("post_abort_done", done, 0);
                    end
                    psum_valid = 1'b0;
                    check_perf();
                    return;
                end

                if (cyc == exp_done) begin
                    reached = 1'b1;
                    break;
                end
            end
        end
        if (!reached) check("timeout", 0, 1);

        cmd_valid  = 1'b0;
        psum_valid = 1'($urandom % 2);
        step();
        m_busy++;
        check("end_wr_en", wr_en_out, 0);
        check("end_done", done, 0);
        check("end_busy", busy, 0);
        check("end_ready", cmd_ready, 1);
        check_perf();
    endtask

    initial begin
        int r;
        int len;
        do_reset(3);

        run_burst(10, 4, 1'b1, 0, 1'b0, 0);    // basic accumulate burst
        run_burst(254, 4, 1'b0, 0, 1'b0, 0);   // pointer wrap
        run_burst(0, 3, 1'b0, 2, 1'b0, 0);     // stalls: 2 stall cycles
        run_burst(5, 0, 1'b1, 1, 1'b0, 0);     // zero-length burst
        run_burst(100, 8, 1'b1, 0, 1'b0, 2);   // reset after 2 of 8 rows
        run_burst(77, 5, 1'b0, 1, 1'b0, 0);    // next command from its own base
        run_burst(200, 6, 1'b1, 1, 1'b1, 0);   // cmd_valid held through DRAIN/DONE
        run_burst(3, 300, 1'b1, 1, 1'b0, 0);   // length clamp to ACCUM_ROW

        for (int i = 0; i < 12; i++) begin
            r = int'($urandom % 8);
            if (r == 0)      len = 0;
            else if (r == 7) len = int'($urandom_range(250, 511));
            else             len = int'($urandom_range(1, 20));
            run_burst(int'($urandom % ACCUM_ROW), len, 1'($urandom % 2), 1, 1'($urandom % 2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_wr_seq.md
ACCUM_WR_SEQ -- requirements
Module: accum_wr_seq

Interface
REQ-001 SHALL have parameter SYS_COL, default 16, systolic array column count (skew depth of the downstream write-skew stage).
REQ-002 SHALL have parameter ACCUM_ROW, default 256, accumulator rows; localparam ADDR_WIDTH = $clog2(ACCUM_ROW), CNT_WIDTH = ADDR_WIDTH+1.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  write-burst command valid.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_base  input  ADDR_WIDTH  first accumulator row of the burst.
REQ-008 SHALL have port cmd_len  input  CNT_WIDTH  row count, 0..ACCUM_ROW.
REQ-009 SHALL have port cmd_accum  input  1  1 = accumulate, 0 = overwrite.
REQ-010 SHALL have port psum_valid  input  1  systolic array column-0 partial sum valid this cycle.
REQ-011 SHALL have port wr_en_out  output  1  write enable to the downstream write-skew stage.
REQ-012 SHALL have port wr_addr_out  output  ADDR_WIDTH  write row to the downstream write-skew stage.
REQ-013 SHALL have port wr_accum_out  output  1  latched cmd_accum, qualified by wr_en_out.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 SHALL drive cmd_ready = 1 only in IDLE.
REQ-018 SHALL, on acceptance in IDLE, latch base into row pointer, len into remaining count, accum into mode; go to RUN if len != 0, else DONE.
REQ-019 SHALL, in RUN, for each cycle with psum_valid = 1, register wr_en_out = 1, wr_addr_out = pointer, wr_accum_out = mode (1-cycle latency), then increment pointer and decrement remaining.
REQ-020 SHALL, in RUN with psum_valid = 0, register wr_en_out = 0 and hold pointer and remaining (stall).
REQ-021 SHALL wrap the pointer from ACCUM_ROW-1 to 0 (modulo ACCUM_ROW).
REQ-022 SHALL move RUN -> DRAIN when the last row is issued (remaining reaches 0).
REQ-023 SHALL hold DRAIN for SYS_COL cycles so the final skewed column write lands; done SHALL pulse exactly SYS_COL+1 cycles after the last wr_en_out high cycle.
REQ-024 SHALL, in DONE, assert done for one cycle and return to IDLE; done for len = 0 SHALL pulse the cycle after acceptance.
REQ-025 SHALL ignore psum_valid in IDLE, DRAIN, DONE (wr_en_out = 0).
REQ-026 SHALL keep wr_addr_out and wr_accum_out at their last values when wr_en_out = 0.
REQ-027 SHALL treat cmd_len > ACCUM_ROW as ACCUM_ROW.

Reset
REQ-028 SHALL, with rstn = 0 at a clock edge, set state IDLE, pointer, remaining, mode, wr_en_out, wr_addr_out, wr_accum_out, done to 0; busy = 0, cmd_ready = 1 following IDLE.
REQ-029 SHALL, on reset mid-burst, discard the burst with no done pulse and no further wr_en_out.

Configuration
REQ-030 SHALL, with macro ACCUM_WR_SEQ_PERF_EN defined, add outputs perf_busy_cycles (32) counting cycles busy = 1 and perf_stall_cycles (32) counting RUN cycles with psum_valid = 0, both saturating at all-ones, cleared by reset only.
REQ-031 SHALL, without ACCUM_WR_SEQ_PERF_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, then base=10, len=4, accum=1, psum_valid held 1 -> wr_en_out high 4 consecutive cycles, addr 10,11,12,13, wr_accum_out=1, done SYS_COL+1 cycles after addr 13 (17 at default).
REQ-033 SHALL cover: base=254, len=4, ACCUM_ROW=256 -> addresses 254,255,0,1.
REQ-034 SHALL cover: len=3, psum_valid pattern 1,0,0,1,1 -> addresses 0,_,_,1,2; perf_stall_cycles = 2 with ACCUM_WR_SEQ_PERF_EN.
REQ-035 SHALL cover: len=0 -> no wr_en_out, done pulse one cycle after acceptance, cmd_ready low for 1 cycle.
REQ-036 SHALL cover: rstn low after 2 of 8 rows -> wr_en_out 0 next cycle, no done, next command accepted and starts from its own base.
REQ-037 SHALL cover: cmd_valid held high during DRAIN/DONE -> not accepted until IDLE; psum_valid in DRAIN produces no write.
